div_unit: RTL

Iterative 32-bit integer divider for the pipelined MIPS datapath; the subtractive counterpart to the ALU-based add path used for PC and branch targets. It accepts one divide request per start pulse. It produces the quotient and remainder through a restoring shift-subtract loop, one quotient bit per clock. The hazard unit stalls on `busy_o`, and the result is written to HI/LO when `done_o` pulses.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_step.sv | 25 ++
 rtl/div_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared constants for the MIPS divide unit: FSM encoding, iteration count,
// divide-by-zero quotient and the ALU control codes shared with the ALU decoder.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  localparam int unsigned DIV_ITER     = 32;
  localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

  localparam logic [3:0]  ALU_ADD      = 4'b0010;
  localparam logic [3:0]  ALU_SUB      = 4'b0110;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: trial-subtract the divisor from the
// shifted partial remainder and produce the next remainder and quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_ITER
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic             q_msb_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] r_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;

  assign w_shift = {r_i, q_msb_i};
  assign w_trial = w_shift - {1'b0, b_i};
  assign q_bit_o = ~w_trial[WIDTH];

  // The partial remainder always stays below b, so WIDTH bits hold it exactly.
  assign r_o = q_bit_o ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU unit: one quotient bit per clock, sign fix-up afterwards,
// results held on quo_o (LO) / rem_o (HI) until the next divide completes.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_ITER
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  div_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_a;
  logic             r_neg_b;
  logic [WIDTH-1:0] r_src1;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;

  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_rem_next;
  logic             w_q_bit;

  // Operand magnitudes; only negative operands of a signed divide are flipped.
  assign w_neg_a = signed_i & src1_i[WIDTH-1];
  assign w_neg_b = signed_i & src2_i[WIDTH-1];
  assign w_mag_a = w_neg_a ? (~src1_i + WIDTH'(1)) : src1_i;
  assign w_mag_b = w_neg_b ? (~src2_i + WIDTH'(1)) : src2_i;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r_i     (r_rem),
    .q_msb_i (r_q[WIDTH-1]),
    .b_i     (r_b),
    .r_o     (w_rem_next),
    .q_bit_o (w_q_bit)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_neg_a    <= 1'b0;
      r_neg_b    <= 1'b0;
      r_src1     <= '0;
      r_b        <= '0;
      r_rem      <= '0;
      r_q        <= '0;
      quo_o      <= '0;
      rem_o      <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      div_zero_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          busy_o <= 1'b0;
          if (start_i) begin
            busy_o  <= 1'b1;
            r_neg_a <= w_neg_a;
            r_neg_b <= w_neg_b;
            r_src1  <= src1_i;
            r_b     <= w_mag_b;
            r_rem   <= '0;
            r_q     <= w_mag_a;
            r_cnt   <= '0;
            r_state <= (src2_i == '0) ? ST_DONE : ST_CALC;
          end
        end
        ST_CALC: begin
          r_rem <= w_rem_next;
          r_q   <= {r_q[WIDTH-2:0], w_q_bit};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          quo_o      <= (r_neg_a ^ r_neg_b) ? (~r_q + WIDTH'(1)) : r_q;
          rem_o      <= r_neg_a ? (~r_rem + WIDTH'(1)) : r_rem;
          div_zero_o <= 1'b0;
          r_state    <= ST_DONE;
        end
        ST_DONE: begin
          done_o  <= 1'b1;
          r_state <= ST_IDLE;
          // A zero divisor bypasses CALC/FIX and loads its fixed result here.
          if (r_b == '0) begin
            quo_o      <= WIDTH'(DIV_ZERO_QUO);
            rem_o      <= r_src1;
            div_zero_o <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
